// File: rtl/ula_seq.sv
// ula_seq: command sequencer feeding a combinational ULA, with result hold and accumulator.
// Ports: clk/rst (sync, active-high); in_* valid/ready command channel with operands,
// opcode and accumulator controls; alu_a/alu_b/alu_op registered to the ULA and alu_c
// its result; out_* valid/ready result channel with zero flag; acc accumulator;
// op_count counts delivered results modulo 2^N.
module ula_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   in_op,
    input  logic         in_use_acc,
    input  logic         in_acc_clr,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_zero,
    output logic [N-1:0] acc,
    output logic [N-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state;
    assign in_ready = state == IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            out_data  <= '0;
            out_zero  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // clear wins over accumulator reuse, so a cleared chain starts from 0
                    alu_a  <= in_acc_clr ? '0 : in_use_acc ? acc : in_a;
                    alu_b  <= in_b;
                    alu_op <= in_op;
                    if (in_acc_clr) acc <= '0;
                    state  <= EXEC;
                end
                EXEC: begin
                    out_data  <= alu_c;
                    acc       <= alu_c;
                    out_zero  <= alu_c == '0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    op_count  <= op_count + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: randomized and directed self-checking bench for ula_seq with a ULA model.
module tb_ula_seq;
    localparam int N = 8;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, in_use_acc = 0, in_acc_clr = 0;
    logic [N-1:0] in_a = 0, in_b = 0, alu_a, alu_b, alu_c, out_data, acc, op_count;
    logic [2:0] in_op = 0, alu_op;
    logic out_valid, out_ready = 0, out_zero;
    int checks = 0, failures = 0;
    logic [N-1:0] m_acc = 0, m_count = 0;

    ula_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
        .in_acc_clr(in_acc_clr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .acc(acc), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // combinational ULA the stage feeds
    always_comb begin
        alu_c = alu_a | alu_b;
        case (alu_op)
            3'b000: alu_c = alu_a + alu_b;
            3'b001: alu_c = alu_a - alu_b;
            3'b010: alu_c = alu_a * alu_b;
            3'b011: alu_c = alu_a & alu_b;
            default: alu_c = alu_a | alu_b;
        endcase
    end

    function automatic logic [N-1:0] ref_f(input int unsigned a, b, input logic [2:0] op);
        int unsigned x;
        if (op[2]) x = a | b;
        else if (op == 3'd0) x = (a + b) % 256;
        else if (op == 3'd1) x = (a + 256 - b) % 256;
        else if (op == 3'd2) x = (a * b) % 256;
        else x = a & b;
        return N'(x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        tick();
        rst = 0;
        m_acc = 0;
        m_count = 0;
    endtask

    task automatic cmd(input logic [N-1:0] a, b, input logic [2:0] op, input logic ua, clr,
                       input int stall, input logic offer);
        logic [N-1:0] ea, r;
        ea = clr ? '0 : ua ? m_acc : a;
        r = ref_f(ea, b, op);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1; in_a = a; in_b = b; in_op = op; in_use_acc = ua; in_acc_clr = clr;
        tick();
        in_valid = 0; in_a = N'($urandom); in_b = N'($urandom); in_op = 3'($urandom);
        in_use_acc = 1'($urandom); in_acc_clr = 1'($urandom);
        out_ready = 1'($urandom);
        chk("alu_a", 32'(alu_a), 32'(ea));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("exec_valid", 32'(out_valid), 0);
        chk("exec_ready", 32'(in_ready), 0);
        if (clr) chk("acc_clr", 32'(acc), 0);
        tick();
        m_acc = r;
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'(r));
        chk("out_zero", 32'(out_zero), 32'(r == 0));
        chk("acc", 32'(acc), 32'(r));
        for (int i = 0; i < stall; i++) begin
            out_ready = 0;
            in_valid = 1'($urandom);
            tick();
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'(r));
            chk("stall_acc", 32'(acc), 32'(r));
            chk("stall_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        in_valid = offer;
        tick();
        out_ready = 0;
        in_valid = 0;
        m_count++;
        chk("xfer_valid", 32'(out_valid), 0);
        chk("xfer_in_ready", 32'(in_ready), 1);
        chk("op_count", 32'(op_count), 32'(m_count));
    endtask

    initial begin
        tick();
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_count", 32'(op_count), 0);
        chk("rst_zero", 32'(out_zero), 1);
        chk("rst_alu_op", 32'(alu_op), 0);
        cmd(200, 100, 3'b000, 0, 0, 0, 0);
        chk("add_44", 32'(out_data), 8'h2C);
        cmd(5, 7, 3'b001, 0, 0, 0, 0);
        chk("sub_254", 32'(out_data), 254);
        cmd(20, 13, 3'b010, 0, 0, 0, 0);
        chk("mul_4", 32'(out_data), 4);
        cmd(8'hF0, 8'h0F, 3'b011, 0, 0, 0, 0);
        chk("and_zero", 32'(out_zero), 1);
        cmd(8'h0A, 8'h50, 3'b101, 0, 0, 0, 0);
        chk("or_5a", 32'(out_data), 8'h5A);
        cmd(3, 4, 3'b000, 0, 0, 0, 0);
        cmd(0, 2, 3'b010, 1, 0, 0, 0);
        chk("chain_14", 32'(out_data), 14);
        cmd(8'hAA, 9, 3'b000, 1, 1, 0, 0);
        chk("clr_9", 32'(out_data), 9);
        cmd(8'h30, 8'h0C, 3'b000, 0, 0, 5, 1);
        chk("bp_3c", 32'(acc), 8'h3C);
        // reset during EXEC
        in_valid = 1; in_a = 9; in_b = 9; in_op = 0; in_use_acc = 0; in_acc_clr = 0;
        tick();
        in_valid = 0;
        do_reset();
        chk("rexec_ready", 32'(in_ready), 1);
        chk("rexec_valid", 32'(out_valid), 0);
        chk("rexec_acc", 32'(acc), 0);
        chk("rexec_count", 32'(op_count), 0);
        tick();
        chk("rexec_quiet", 32'(out_valid), 0);
        // reset during DONE
        in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        chk("rdone_pending", 32'(out_valid), 1);
        do_reset();
        chk("rdone_valid", 32'(out_valid), 0);
        chk("rdone_acc", 32'(acc), 0);
        chk("rdone_count", 32'(op_count), 0);
        chk("rdone_zero", 32'(out_zero), 1);
        for (int k = 0; k < 300; k++)
            cmd(N'($urandom), N'($urandom), 3'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0),
                $urandom_range(0, 3), 1'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule
